// File: rtl/fuzz_stim_engine.sv
// fuzz_stim_engine: serial 32-bit LCG stimulus generator with a 32-bit MISR over the DUT response.
// One vector every NL+1 cycles; optional per-vector trace log when FUZZ_STIM_TRACE_EN is defined.
module fuzz_stim_engine #(
    parameter int IN_W   = 258,
    parameter int OUT_W  = 330,
    parameter int CNT_W  = 32,
    parameter int SETTLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [31:0]      seed,
    input  logic [CNT_W-1:0] num_cycles,
    input  logic [OUT_W-1:0] dut_out,
    output logic [IN_W-1:0]  stim,
    output logic             stim_strobe,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cyc_count,
    output logic [31:0]      signature
);
    localparam int NL   = (IN_W + 31) / 32;
    localparam int NO   = (OUT_W + 31) / 32;
    localparam int TOPW = IN_W - 32 * (NL - 1);
    localparam int LW   = (NL > 1) ? $clog2(NL) : 1;
    localparam int SW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [31:0] LCG_A = 32'h41C64E6D;
    localparam logic [31:0] LCG_C = 32'h00003039;
    localparam logic [31:0] POLY  = 32'h04C11DB7;

    typedef enum logic [2:0] {
        S_IDLE, S_GEN, S_APPLY, S_SETTLE, S_FINAL, S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [31:0]       lcg, lcg_step;
    logic [IN_W-1:0]   shadow;
    logic [LW-1:0]     lane_idx;
    logic [SW-1:0]     settle_cnt;
    logic              first_vec;
    logic [CNT_W-1:0]  num_lat, cyc_inc;
    logic [NO*32-1:0]  out_pad;
    logic [31:0]       fold, sig_nxt;
    logic              load_run, gen_en, apply_en, fold_en;

    assign lcg_step = lcg * LCG_A + LCG_C;
    assign cyc_inc  = cyc_count + CNT_W'(1);
    assign out_pad  = (NO*32)'(dut_out);

    always_comb begin
        fold = '0;
        for (int i = 0; i < NO; i++) fold = fold ^ out_pad[i*32 +: 32];
    end

    assign sig_nxt = {signature[30:0], 1'b0} ^ (signature[31] ? POLY : 32'h0) ^ fold;

    assign busy = (state != S_IDLE) && (state != S_DONE);
    assign done = (state == S_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        load_run  = 1'b0;
        gen_en    = 1'b0;
        apply_en  = 1'b0;
        fold_en   = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (abort) begin
                    state_nxt = S_IDLE;
                end else if (start) begin
                    load_run  = 1'b1;
                    state_nxt = S_GEN;
                end
            end
            S_GEN: begin
                gen_en = 1'b1;
                if (lane_idx == LW'(NL - 1)) state_nxt = S_APPLY;
            end
            S_APPLY: begin
                apply_en = 1'b1;
                fold_en  = 1'b1;
                if (first_vec) begin
                    if (SETTLE > 0)            state_nxt = S_SETTLE;
                    else if (num_lat == '0)    state_nxt = S_FINAL;
                    else                       state_nxt = S_GEN;
                end else if (cyc_inc == num_lat) begin
                    state_nxt = S_FINAL;
                end else begin
                    state_nxt = S_GEN;
                end
            end
            S_SETTLE: begin
                if (settle_cnt == SW'(SETTLE - 1))
                    state_nxt = (num_lat == '0) ? S_FINAL : S_GEN;
            end
            S_FINAL: begin
                fold_en   = 1'b1;
                state_nxt = S_DONE;
            end
            default: state_nxt = S_IDLE;
        endcase
        // Abort freezes stim, signature and cyc_count where they are.
        if (abort && busy) begin
            state_nxt = S_IDLE;
            gen_en    = 1'b0;
            apply_en  = 1'b0;
            fold_en   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lcg         <= '0;
            shadow      <= '0;
            lane_idx    <= '0;
            settle_cnt  <= '0;
            first_vec   <= 1'b0;
            num_lat     <= '0;
            stim        <= '0;
            stim_strobe <= 1'b0;
            cyc_count   <= '0;
            signature   <= '0;
        end else begin
            stim_strobe <= apply_en;
            if (load_run) begin
                lcg        <= seed;
                num_lat    <= num_cycles;
                cyc_count  <= '0;
                signature  <= '0;
                first_vec  <= 1'b1;
                lane_idx   <= '0;
                settle_cnt <= '0;
            end
            if (gen_en) begin
                lcg <= lcg_step;
                for (int k = 0; k < NL - 1; k++)
                    if (lane_idx == LW'(k)) shadow[k*32 +: 32] <= lcg_step;
                if (lane_idx == LW'(NL - 1))
                    shadow[IN_W-1 -: TOPW] <= lcg_step[TOPW-1:0];
                lane_idx <= (lane_idx == LW'(NL - 1)) ? '0 : lane_idx + LW'(1);
            end
            if (apply_en) begin
                stim      <= shadow;
                first_vec <= 1'b0;
                if (!first_vec) cyc_count <= cyc_inc;
            end
            if (fold_en) signature <= sig_nxt;
            if (state == S_SETTLE) settle_cnt <= settle_cnt + SW'(1);
        end
    end

`ifdef FUZZ_STIM_TRACE_EN
    always @(posedge clk) begin
        if (!rst && (state == S_APPLY || state == S_FINAL))
            $write("CYCLE=%0d IN=%0h OUT=%0h\n", cyc_count, stim, dut_out);
    end
`endif

endmodule

// File: tb/tb_fuzz_stim_engine.sv
// tb_fuzz_stim_engine: random-seed runs of fuzz_stim_engine against a queue-based LCG/MISR reference,
// with a combinational stub DUT whose response is a known function of stim.
`timescale 1ns/1ps
module tb_fuzz_stim_engine;
    localparam int IN_W   = 258;
    localparam int OUT_W  = 330;
    localparam int CNT_W  = 32;
    localparam int SETTLE = 1;
    localparam int NL     = (IN_W + 31) / 32;
    localparam int XW     = OUT_W - IN_W;
    localparam logic [31:0] LCG_A = 32'h41C64E6D;
    localparam logic [31:0] LCG_C = 32'h00003039;
    localparam logic [31:0] POLY  = 32'h04C11DB7;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             abort;
    logic [31:0]      seed;
    logic [CNT_W-1:0] num_cycles;
    logic [OUT_W-1:0] dut_out;
    logic [IN_W-1:0]  stim;
    logic             stim_strobe;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] cyc_count;
    logic [31:0]      signature;

    int total = 0;
    int bad   = 0;

    int            dut_mode;
    logic [XW-1:0] key;

    always #5 clk = ~clk;

    assign dut_out = (dut_mode == 0) ? '0 :
                     (dut_mode == 1) ? '1 : {stim[XW-1:0] ^ key, stim};

    fuzz_stim_engine #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed),
        .num_cycles(num_cycles), .dut_out(dut_out), .stim(stim),
        .stim_strobe(stim_strobe), .busy(busy), .done(done),
        .cyc_count(cyc_count), .signature(signature)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    // ---------------- reference model ----------------
    logic [IN_W-1:0] exp_vec[$];
    logic [31:0]     exp_sig;
    logic [IN_W-1:0] last_stim;

    function automatic logic [OUT_W-1:0] dut_model(input logic [IN_W-1:0] s);
        if (dut_mode == 0) return '0;
        if (dut_mode == 1) return '1;
        return {s[XW-1:0] ^ key, s};
    endfunction

    function automatic logic [31:0] fold_ref(input logic [OUT_W-1:0] v);
        logic [31:0] f;
        f = '0;
        for (int i = 0; i < OUT_W; i++) f[i % 32] = f[i % 32] ^ v[i];
        return f;
    endfunction

    function automatic logic [31:0] misr_ref(input logic [31:0] s, input logic [31:0] f);
        return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    // Vectors v0..vn; signature folds the response to the pre-run stim, then to v0..vn.
    task automatic model_run(input logic [31:0] s, input int n, input logic [IN_W-1:0] init);
        logic [31:0]      x;
        logic [NL*32-1:0] w;
        exp_vec.delete();
        x = s;
        for (int v = 0; v <= n; v++) begin
            w = '0;
            for (int k = 0; k < NL; k++) begin
                x = x * LCG_A + LCG_C;
                w = {x, w[NL*32-1:32]};
            end
            exp_vec.push_back(w[IN_W-1:0]);
        end
        exp_sig = misr_ref(32'h0, fold_ref(dut_model(init)));
        for (int v = 0; v <= n; v++) exp_sig = misr_ref(exp_sig, fold_ref(dut_model(exp_vec[v])));
    endtask

    // Cycle (counted from the first cycle after start) in which strobe k is visible.
    function automatic int exp_t(input int k);
        return (k == 0) ? NL + 2 : NL + 2 + SETTLE + (NL + 1) * k;
    endfunction

    function automatic int exp_done_t(input int n);
        return (n == 0) ? NL + 2 + SETTLE + 1 : exp_t(n) + 1;
    endfunction

    // ---------------- run driver (observation only) ----------------
    logic [IN_W-1:0]  obs_vec[$];
    int               obs_t[$];
    int               obs_done_t;
    bit               obs_timeout;
    logic             obs_busy1;
    logic [31:0]      obs_sig;
    logic [CNT_W-1:0] obs_cnt;

    task automatic do_run(input logic [31:0] s, input int n, input int poke_at);
        int cyc;
        obs_vec.delete();
        obs_t.delete();
        obs_timeout = 0;
        obs_done_t  = -1;
        @(negedge clk);
        seed = s; num_cycles = CNT_W'(n); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        obs_busy1 = busy;
        while (1) begin
            if (stim_strobe) begin
                obs_vec.push_back(stim);
                obs_t.push_back(cyc);
            end
            if (done) begin
                obs_done_t = cyc;
                break;
            end
            if (cyc >= 100 + 12 * n) begin
                obs_timeout = 1;
                break;
            end
            if (cyc == poke_at) begin
                start = 1'b1; seed = ~s; num_cycles = '0;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        obs_sig = signature;
        obs_cnt = cyc_count;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        last_stim = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; seed = '0; num_cycles = '0;
        dut_mode = 0; key = '0; last_stim = '0;
        repeat (2) @(negedge clk);
        total++; if (stim !== '0) begin bad++; $display("FAIL reset_stim: got %h want 0", stim); end
        total++; if (stim_strobe !== 1'b0) begin bad++; $display("FAIL reset_strobe: got %b want 0", stim_strobe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (cyc_count !== '0) begin bad++; $display("FAIL reset_cyc: got %0d want 0", cyc_count); end
        total++; if (signature !== '0) begin bad++; $display("FAIL reset_sig: got %h want 0", signature); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_vector();
        logic [31:0] lane0;
        dut_mode = 2; key = XW'({$urandom, $urandom, $urandom});
        model_run(32'h0, 0, last_stim);
        do_run(32'h0, 0, -1);
        total++; if (obs_timeout) begin bad++; $display("FAIL single_timeout: done not seen, got 0 want 1"); end
        total++; if (obs_busy1 !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", obs_busy1); end
        total++; if (obs_vec.size() != 1) begin bad++; $display("FAIL single_strobes: got %0d want 1", obs_vec.size()); end
        if (obs_vec.size() > 0) begin
            lane0 = obs_vec[0][31:0];
            total++; if (lane0 !== 32'h00003039) begin bad++; $display("FAIL single_lane0: got %h want 00003039", lane0); end
            total++; if (obs_vec[0] !== exp_vec[0]) begin bad++; $display("FAIL single_vec: got %h want %h", obs_vec[0], exp_vec[0]); end
            total++; if (obs_t[0] != exp_t(0)) begin bad++; $display("FAIL single_strobe_t: got %0d want %0d", obs_t[0], exp_t(0)); end
        end
        total++; if (obs_done_t != exp_done_t(0)) begin bad++; $display("FAIL single_done_t: got %0d want %0d", obs_done_t, exp_done_t(0)); end
        total++; if (obs_cnt !== '0) begin bad++; $display("FAIL single_cyc: got %0d want 0", obs_cnt); end
        total++; if (obs_sig !== exp_sig) begin bad++; $display("FAIL single_sig: got %h want %h", obs_sig, exp_sig); end
        last_stim = exp_vec[0];
    endtask

    task automatic test_multi_timing();
        logic [31:0] lane0;
        int          last;
        dut_mode = 2;
        model_run(32'h1, 3, last_stim);
        do_run(32'h1, 3, -1);
        total++; if (obs_timeout) begin bad++; $display("FAIL multi_timeout: done not seen, got 0 want 1"); end
        total++; if (obs_vec.size() != 4) begin bad++; $display("FAIL multi_strobes: got %0d want 4", obs_vec.size()); end
        if (obs_vec.size() > 0) begin
            lane0 = obs_vec[0][31:0];
            total++; if (lane0 !== 32'h41C67EA6) begin bad++; $display("FAIL multi_lane0: got %h want 41c67ea6", lane0); end
            last = obs_t[obs_t.size() - 1];
            total++; if (obs_done_t != last + 1) begin bad++; $display("FAIL multi_done_after_strobe: got %0d want %0d", obs_done_t, last + 1); end
        end
        for (int k = 0; k < obs_vec.size() && k < 4; k++) begin
            total++; if (obs_vec[k] !== exp_vec[k]) begin bad++; $display("FAIL multi_vec%0d: got %h want %h", k, obs_vec[k], exp_vec[k]); end
            total++; if (obs_t[k] != exp_t(k)) begin bad++; $display("FAIL multi_t%0d: got %0d want %0d", k, obs_t[k], exp_t(k)); end
        end
        total++; if (obs_done_t != exp_done_t(3)) begin bad++; $display("FAIL multi_done_t: got %0d want %0d", obs_done_t, exp_done_t(3)); end
        total++; if (obs_cnt !== CNT_W'(3)) begin bad++; $display("FAIL multi_cyc: got %0d want 3", obs_cnt); end
        total++; if (obs_sig !== exp_sig) begin bad++; $display("FAIL multi_sig: got %h want %h", obs_sig, exp_sig); end
        last_stim = exp_vec[3];
    endtask

    task automatic test_sig_zero();
        logic [31:0] s;
        dut_mode = 0; s = $urandom;
        model_run(s, 5, last_stim);
        do_run(s, 5, -1);
        total++; if (obs_vec.size() != 6) begin bad++; $display("FAIL zero_strobes: got %0d want 6", obs_vec.size()); end
        total++; if (obs_sig !== 32'h0) begin bad++; $display("FAIL zero_sig: got %h want 0", obs_sig); end
        total++; if (obs_cnt !== CNT_W'(5)) begin bad++; $display("FAIL zero_cyc: got %0d want 5", obs_cnt); end
        last_stim = exp_vec[5];
    endtask

    task automatic test_sig_ones();
        logic [31:0] s;
        dut_mode = 1; s = $urandom;
        model_run(s, 0, last_stim);
        do_run(s, 0, -1);
        total++; if (obs_sig !== 32'h00000401) begin bad++; $display("FAIL ones_sig: got %h want 00000401", obs_sig); end
        total++; if (obs_sig !== exp_sig) begin bad++; $display("FAIL ones_sig_model: got %h want %h", obs_sig, exp_sig); end
        last_stim = exp_vec[0];
    endtask

    task automatic test_repeat();
        logic [31:0] s, s2, lane_a, lane_b;
        dut_mode = 2; key = XW'({$urandom, $urandom, $urandom}); s = $urandom;
        for (int r = 0; r < 2; r++) begin
            do_reset();
            model_run(s, 2, last_stim);
            do_run(s, 2, -1);
            total++; if (obs_vec.size() != 3) begin bad++; $display("FAIL repeat%0d_strobes: got %0d want 3", r, obs_vec.size()); end
            for (int k = 0; k < obs_vec.size() && k < 3; k++) begin
                total++; if (obs_vec[k] !== exp_vec[k]) begin bad++; $display("FAIL repeat%0d_vec%0d: got %h want %h", r, k, obs_vec[k], exp_vec[k]); end
            end
            total++; if (obs_sig !== exp_sig) begin bad++; $display("FAIL repeat%0d_sig: got %h want %h", r, obs_sig, exp_sig); end
        end
        lane_a = exp_vec[0][31:0];
        s2 = s ^ 32'h8000_0001;
        do_reset();
        model_run(s2, 0, last_stim);
        do_run(s2, 0, -1);
        if (obs_vec.size() > 0) begin
            lane_b = obs_vec[0][31:0];
            total++; if (lane_b === lane_a) begin bad++; $display("FAIL seed_change_lane0: got %h want anything but %h", lane_b, lane_a); end
            total++; if (obs_vec[0] !== exp_vec[0]) begin bad++; $display("FAIL seed_change_vec: got %h want %h", obs_vec[0], exp_vec[0]); end
        end else begin
            total++; bad++; $display("FAIL seed_change_strobes: got 0 want 1");
        end
        last_stim = exp_vec[0];
    endtask

    task automatic test_start_ignored();
        logic [31:0] s;
        dut_mode = 2; s = $urandom;
        model_run(s, 2, last_stim);
        do_run(s, 2, 15);
        total++; if (obs_vec.size() != 3) begin bad++; $display("FAIL busy_start_strobes: got %0d want 3", obs_vec.size()); end
        for (int k = 0; k < obs_vec.size() && k < 3; k++) begin
            total++; if (obs_vec[k] !== exp_vec[k]) begin bad++; $display("FAIL busy_start_vec%0d: got %h want %h", k, obs_vec[k], exp_vec[k]); end
        end
        total++; if (obs_cnt !== CNT_W'(2)) begin bad++; $display("FAIL busy_start_cyc: got %0d want 2", obs_cnt); end
        total++; if (obs_sig !== exp_sig) begin bad++; $display("FAIL busy_start_sig: got %h want %h", obs_sig, exp_sig); end
        last_stim = exp_vec[2];
    endtask

    task automatic test_random();
        logic [31:0] s;
        int          n;
        dut_mode = 2;
        for (int it = 0; it < 4; it++) begin
            s = $urandom; n = $urandom_range(0, 4);
            key = XW'({$urandom, $urandom, $urandom});
            model_run(s, n, last_stim);
            do_run(s, n, -1);
            total++; if (obs_vec.size() != n + 1) begin bad++; $display("FAIL rand%0d_strobes: got %0d want %0d", it, obs_vec.size(), n + 1); end
            for (int k = 0; k < obs_vec.size() && k <= n; k++) begin
                total++; if (obs_vec[k] !== exp_vec[k]) begin bad++; $display("FAIL rand%0d_vec%0d: got %h want %h", it, k, obs_vec[k], exp_vec[k]); end
                total++; if (obs_t[k] != exp_t(k)) begin bad++; $display("FAIL rand%0d_t%0d: got %0d want %0d", it, k, obs_t[k], exp_t(k)); end
            end
            total++; if (obs_done_t != exp_done_t(n)) begin bad++; $display("FAIL rand%0d_done_t: got %0d want %0d", it, obs_done_t, exp_done_t(n)); end
            total++; if (obs_cnt !== CNT_W'(n)) begin bad++; $display("FAIL rand%0d_cyc: got %0d want %0d", it, obs_cnt, n); end
            total++; if (obs_sig !== exp_sig) begin bad++; $display("FAIL rand%0d_sig: got %h want %h", it, obs_sig, exp_sig); end
            last_stim = exp_vec[n];
        end
    endtask

    task automatic test_abort();
        int          cyc, pre, post, done_seen;
        logic [31:0] s, sig1;
        dut_mode = 2; s = $urandom;
        model_run(s, 3, last_stim);
        sig1 = misr_ref(32'h0, fold_ref(dut_model(last_stim)));
        pre = 0; post = 0; done_seen = 0;
        @(negedge clk);
        seed = s; num_cycles = CNT_W'(3); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (cyc = 1; cyc < 14; cyc++) begin
            if (stim_strobe) pre++;
            @(negedge clk);
        end
        if (stim_strobe) pre++;
        abort = 1'b1; start = 1'b1; seed = ~s;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL abort_done: got %b want 0", done); end
        for (int i = 0; i < 30; i++) begin
            if (stim_strobe) post++;
            if (done) done_seen++;
            @(negedge clk);
        end
        total++; if (pre != 1) begin bad++; $display("FAIL abort_pre_strobes: got %0d want 1", pre); end
        total++; if (post != 0) begin bad++; $display("FAIL abort_post_strobes: got %0d want 0", post); end
        total++; if (done_seen != 0) begin bad++; $display("FAIL abort_done_seen: got %0d want 0", done_seen); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_start_dropped: busy got %b want 0", busy); end
        total++; if (stim !== exp_vec[0]) begin bad++; $display("FAIL abort_stim_hold: got %h want %h", stim, exp_vec[0]); end
        total++; if (cyc_count !== '0) begin bad++; $display("FAIL abort_cyc_hold: got %0d want 0", cyc_count); end
        total++; if (signature !== sig1) begin bad++; $display("FAIL abort_sig_hold: got %h want %h", signature, sig1); end
        last_stim = exp_vec[0];
    endtask

    task automatic test_reset_midrun();
        dut_mode = 2;
        @(negedge clk);
        seed = 32'd7; num_cycles = CNT_W'(4); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        rst = 1'b1;
        #1;
        total++; if (stim !== '0) begin bad++; $display("FAIL midrst_stim: got %h want 0", stim); end
        total++; if (stim_strobe !== 1'b0) begin bad++; $display("FAIL midrst_strobe: got %b want 0", stim_strobe); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL midrst_done: got %b want 0", done); end
        total++; if (cyc_count !== '0) begin bad++; $display("FAIL midrst_cyc: got %0d want 0", cyc_count); end
        total++; if (signature !== '0) begin bad++; $display("FAIL midrst_sig: got %h want 0", signature); end
        repeat (2) @(negedge clk);
        total++; if (stim_strobe !== 1'b0) begin bad++; $display("FAIL midrst_strobe_held: got %b want 0", stim_strobe); end
        rst = 1'b0;
        last_stim = '0;
        model_run(32'h0, 0, last_stim);
        do_run(32'h0, 0, -1);
        total++; if (obs_vec.size() != 1) begin bad++; $display("FAIL midrst_rerun_strobes: got %0d want 1", obs_vec.size()); end
        if (obs_vec.size() > 0) begin
            total++; if (obs_vec[0] !== exp_vec[0]) begin bad++; $display("FAIL midrst_rerun_vec: got %h want %h", obs_vec[0], exp_vec[0]); end
            total++; if (obs_t[0] != exp_t(0)) begin bad++; $display("FAIL midrst_rerun_t: got %0d want %0d", obs_t[0], exp_t(0)); end
        end
        total++; if (obs_done_t != exp_done_t(0)) begin bad++; $display("FAIL midrst_rerun_done_t: got %0d want %0d", obs_done_t, exp_done_t(0)); end
        total++; if (obs_cnt !== '0) begin bad++; $display("FAIL midrst_rerun_cyc: got %0d want 0", obs_cnt); end
        total++; if (obs_sig !== exp_sig) begin bad++; $display("FAIL midrst_rerun_sig: got %h want %h", obs_sig, exp_sig); end
        last_stim = exp_vec[0];
    endtask

    initial begin
        test_reset();
        test_single_vector();
        test_multi_timing();
        test_sig_zero();
        test_sig_ones();
        test_repeat();
        test_start_ignored();
        test_random();
        test_abort();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
